// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone memory arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;  // fetch master
    localparam logic M1 = 1'b1;  // load/store master

endpackage

// File: rtl/wb_arb_watchdog.sv
// Counts strobed cycles without ack; pulses err on the cycle the budget runs out.
module wb_arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ack,
    input  logic clear,
    output logic err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;
    logic          hit;

    // An ack arriving on the last allowed cycle suppresses the error.
    assign hit = active & ~ack & (count == LAST);
    assign err = hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || !active || ack || hit) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter letting fetch (m0) and load/store (m1) share one memory slave port.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_w,
    output logic [DW-1:0] m0_dat_r,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_w,
    output logic [DW-1:0] m1_dat_r,
    output logic          m1_ack,
    output logic          m1_err,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_w,
    input  logic [DW-1:0] s_dat_r,
    input  logic          s_ack,
    output logic          core_select
);

    arb_state_t state, next_state;
    logic       prio, owner;
    logic       gnt_cyc, gnt_stb, gnt_ack, wd_err;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc)  next_state = (prio == M1) ? BUSY1 : BUSY0;
                else if (m0_cyc)       next_state = BUSY0;
                else if (m1_cyc)       next_state = BUSY1;
            end
            // Owner keeps the grant until it drops cyc; no preemption.
            BUSY0:   if (!m0_cyc) next_state = m1_cyc ? BUSY1 : IDLE;
            BUSY1:   if (!m1_cyc) next_state = m0_cyc ? BUSY0 : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            prio  <= M0;
            owner <= M0;
        end else begin
            state <= next_state;
            if (next_state == BUSY0 && state != BUSY0) begin
                owner <= M0;
                prio  <= M1;
            end else if (next_state == BUSY1 && state != BUSY1) begin
                owner <= M1;
                prio  <= M0;
            end
        end
    end

    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        case (state)
            BUSY0: begin
                s_cyc   = m0_cyc;
                s_stb   = m0_stb;
                s_we    = m0_we;
                s_adr   = m0_adr;
                s_dat_w = m0_dat_w;
            end
            BUSY1: begin
                s_cyc   = m1_cyc;
                s_stb   = m1_stb;
                s_we    = m1_we;
                s_adr   = m1_adr;
                s_dat_w = m1_dat_w;
            end
            default: ;
        endcase
    end

    // Gating on cyc drops any stray slave ack during the release cycle.
    assign gnt_cyc = s_cyc;
    assign gnt_stb = s_stb;
    assign gnt_ack = s_ack & gnt_cyc & gnt_stb;

    assign m0_ack      = gnt_ack & (state == BUSY0);
    assign m1_ack      = gnt_ack & (state == BUSY1);
    assign m0_err      = wd_err & (state == BUSY0);
    assign m1_err      = wd_err & (state == BUSY1);
    assign m0_dat_r    = s_dat_r;
    assign m1_dat_r    = s_dat_r;
    assign core_select = owner;

    wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .active (gnt_cyc & gnt_stb),
        .ack    (s_ack),
        .clear  (next_state != state),
        .err    (wd_err)
    );

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: grant order, datapath muxing, watchdog and reset.
module tb_wb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [DW-1:0] m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r, s_dat_w, s_dat_r;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we, s_ack, core_select;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack),
        .core_select(core_select)
    );

    // Advance to just after the next rising edge; inputs are then changed and checked.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_w = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_w = '0;
        s_dat_r = '0; s_ack = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h55; s_ack = 1;
        step();
        step();
        step();
        total++;
        if ({s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err, core_select} !== 8'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=00000000",
                     {s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err, core_select});
        end
        total++;
        if (s_adr !== '0 || s_dat_w !== '0) begin
            bad++;
            $display("FAIL reset_data adr=%h dat=%h want 0/0", s_adr, s_dat_w);
        end
        reset = 0;
        clear_inputs();
        step();
    endtask

    task automatic test_m0_write();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'd3; m0_dat_w = 32'hBEEF;
        #1;
        total++;
        if (s_cyc !== 1'b0) begin
            bad++;
            $display("FAIL wr_no_comb_grant s_cyc=%b want 0", s_cyc);
        end
        step();
        total++;
        if ({s_cyc, s_stb, s_we, core_select} !== 4'b1110 || s_adr !== 32'd3 || s_dat_w !== 32'hBEEF) begin
            bad++;
            $display("FAIL wr_slave_side cyc/stb/we/sel=%b adr=%h dat=%h want 1110 3 beef",
                     {s_cyc, s_stb, s_we, core_select}, s_adr, s_dat_w);
        end
        s_ack = 1;
        #1;
        total++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            bad++;
            $display("FAIL wr_ack m0_ack=%b m1_ack=%b want 1 0", m0_ack, m1_ack);
        end
        step();
        m0_cyc = 0; m0_stb = 0;
        #1;
        total++;
        if (s_cyc !== 1'b0 || m0_ack !== 1'b0) begin
            bad++;
            $display("FAIL wr_release s_cyc=%b m0_ack=%b want 0 0 (stray ack)", s_cyc, m0_ack);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20;
        step();
        total++;
        if (core_select !== 1'b0 || s_adr !== 32'h10 || s_cyc !== 1'b1) begin
            bad++;
            $display("FAIL rr_first sel=%b adr=%h cyc=%b want 0 10 1", core_select, s_adr, s_cyc);
        end
        step();
        total++;
        if (core_select !== 1'b0 || s_adr !== 32'h10) begin
            bad++;
            $display("FAIL rr_no_preempt sel=%b adr=%h want 0 10", core_select, s_adr);
        end
        s_ack = 1;
        #1;
        total++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            bad++;
            $display("FAIL rr_ack_owner m0_ack=%b m1_ack=%b want 1 0", m0_ack, m1_ack);
        end
        step();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        step();
        total++;
        if (core_select !== 1'b1 || s_adr !== 32'h20 || s_cyc !== 1'b1) begin
            bad++;
            $display("FAIL rr_handover sel=%b adr=%h cyc=%b want 1 20 1", core_select, s_adr, s_cyc);
        end
        m1_cyc = 0; m1_stb = 0;
        step();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        step();
        total++;
        if (core_select !== 1'b0 || s_adr !== 32'h10) begin
            bad++;
            $display("FAIL rr_repeat sel=%b adr=%h want 0 10", core_select, s_adr);
        end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_m1_read();
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'd7;
        step();
        s_dat_r = 32'h1234; s_ack = 1;
        #1;
        total++;
        if (core_select !== 1'b1 || s_adr !== 32'd7 || s_we !== 1'b0) begin
            bad++;
            $display("FAIL rd_slave_side sel=%b adr=%h we=%b want 1 7 0", core_select, s_adr, s_we);
        end
        total++;
        if (m1_ack !== 1'b1 || m1_dat_r !== 32'h1234 || m0_ack !== 1'b0) begin
            bad++;
            $display("FAIL rd_data m1_ack=%b m1_dat_r=%h m0_ack=%b want 1 1234 0",
                     m1_ack, m1_dat_r, m0_ack);
        end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_timeout();
        int early_err;
        // Slave silent: err on the 16th strobed cycle, for exactly one cycle.
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h40;
        step();
        early_err = 0;
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            if (m0_err !== 1'b0) early_err++;
            step();
        end
        total++;
        if (early_err != 0) begin
            bad++;
            $display("FAIL to_early got=%0d err cycles want 0", early_err);
        end
        total++;
        if (m0_err !== 1'b1 || m1_err !== 1'b0 || core_select !== 1'b0) begin
            bad++;
            $display("FAIL to_pulse m0_err=%b m1_err=%b sel=%b want 1 0 0", m0_err, m1_err, core_select);
        end
        step();
        total++;
        if (m0_err !== 1'b0 || s_cyc !== 1'b1) begin
            bad++;
            $display("FAIL to_one_cycle m0_err=%b s_cyc=%b want 0 1", m0_err, s_cyc);
        end
        clear_inputs();
        step();
        step();
        // Ack arriving on the 16th cycle wins over the timeout.
        m0_cyc = 1; m0_stb = 1;
        step();
        for (int k = 0; k < TIMEOUT - 1; k++) step();
        s_ack = 1;
        #1;
        total++;
        if (m0_err !== 1'b0 || m0_ack !== 1'b1) begin
            bad++;
            $display("FAIL to_ack_wins m0_err=%b m0_ack=%b want 0 1", m0_err, m0_ack);
        end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_reset_mid_transfer();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h99;
        step();
        total++;
        if (core_select !== 1'b1 || s_cyc !== 1'b1) begin
            bad++;
            $display("FAIL mid_grant sel=%b cyc=%b want 1 1", core_select, s_cyc);
        end
        s_ack = 1;
        reset = 1;
        #1;
        total++;
        if (s_cyc !== 1'b0 || m1_ack !== 1'b0 || core_select !== 1'b0) begin
            bad++;
            $display("FAIL mid_async_reset cyc=%b m1_ack=%b sel=%b want 0 0 0", s_cyc, m1_ack, core_select);
        end
        reset = 0;
        s_ack = 0;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h77;
        step();
        total++;
        if (core_select !== 1'b0 || s_adr !== 32'h77) begin
            bad++;
            $display("FAIL mid_prio_after_reset sel=%b adr=%h want 0 77", core_select, s_adr);
        end
        clear_inputs();
        step();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_m0_write();
        test_round_robin();
        test_m1_read();
        test_timeout();
        test_reset_mid_transfer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
